// File: rtl/count_order_load.sv
`default_nettype none
// ============================================================================
// Module      : count_order_load
// Description : Up/down counter with synchronous parallel load.
//               Priority is reset, then load, then count. Uses a synchronous
//               active-low reset. Define COUNT_ORDER_LOAD_SAT_EN to make the
//               counter saturate at its limits instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module count_order_load #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] vi,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] c_max  = '1;
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = vi;
        end else if (dir) begin
`ifdef COUNT_ORDER_LOAD_SAT_EN
            count_d = (count_q == c_max) ? c_max : count_q + c_one;
`else
            count_d = count_q + c_one;
`endif
        end else begin
`ifdef COUNT_ORDER_LOAD_SAT_EN
            count_d = (count_q == c_zero) ? c_zero : count_q - c_one;
`else
            count_d = count_q - c_one;
`endif
        end
    end

    // Reset is folded in here so it dominates load and count on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= c_zero;
        end else begin
            count_q <= count_d;
        end
    end

    assign out = count_q;

endmodule
`default_nettype wire

// File: tb/tb_count_order_load.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_order_load
// Description : Scoreboard bench for count_order_load with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_order_load;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] vi;
    logic [WIDTH-1:0] out;

    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] last_exp;
    int               checks;
    int               errors;
    int               edge_no;

    count_order_load #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .dir  (dir),
        .load (load),
        .vi   (vi),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every edge that has a queued expectation is checked 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            logic [WIDTH-1:0] e;
            e = sb.pop_front();
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL edge%0d out got %h exp %h", edge_no, out, e);
            end
            edge_no++;
        end
    end

    task automatic step(input logic r, input logic l, input logic d,
                        input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] exp);
        @(negedge clk);
        rst  = r;
        load = l;
        dir  = d;
        vi   = v;
        sb.push_back(exp);
        last_exp = exp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        edge_no = 0;
        rst  = 1'b0;
        load = 1'b0;
        dir  = 1'b0;
        vi   = '0;

        // Reset dominates load
        step(0, 1, 1, 4'h7, 4'h0);
        step(0, 1, 0, 4'h7, 4'h0);
        // Load held, dir ignored
        step(1, 1, 0, 4'h7, 4'h7);
        step(1, 1, 1, 4'h7, 4'h7);
        step(1, 1, 0, 4'h7, 4'h7);
        // Count down through zero
        step(1, 0, 0, 4'h0, 4'h6);
        step(1, 0, 0, 4'h0, 4'h5);
        step(1, 0, 0, 4'h0, 4'h4);
        step(1, 0, 0, 4'h0, 4'h3);
        step(1, 0, 0, 4'h0, 4'h2);
        step(1, 0, 0, 4'h0, 4'h1);
        step(1, 0, 0, 4'h0, 4'h0);
`ifdef COUNT_ORDER_LOAD_SAT_EN
        step(1, 0, 0, 4'h0, 4'h0);
        step(1, 0, 0, 4'h0, 4'h0);
`else
        step(1, 0, 0, 4'h0, 4'hF);
        step(1, 0, 0, 4'h0, 4'hE);
`endif
        // Load C, then count up through the top
        step(1, 1, 0, 4'hC, 4'hC);
        step(1, 0, 1, 4'h0, 4'hD);
        step(1, 0, 1, 4'h0, 4'hE);
        step(1, 0, 1, 4'h0, 4'hF);
`ifdef COUNT_ORDER_LOAD_SAT_EN
        step(1, 0, 1, 4'h0, 4'hF);
        step(1, 0, 1, 4'h0, 4'hF);
`else
        step(1, 0, 1, 4'h0, 4'h0);
        step(1, 0, 1, 4'h0, 4'h1);
`endif
        // Load pulse mid-count, counting resumes from A, then direction flip
        step(1, 1, 1, 4'hA, 4'hA);
        step(1, 0, 1, 4'h3, 4'hB);
        step(1, 0, 1, 4'h3, 4'hC);
        step(1, 0, 0, 4'h3, 4'hB);
        // Reset mid-load aborts it
        step(0, 1, 1, 4'h9, 4'h0);
        // Counting starts from 0 after release
        step(1, 0, 1, 4'h0, 4'h1);
        step(1, 0, 1, 4'h0, 4'h2);
        // Reset asserted between edges must not move out before the edge
        step(0, 0, 1, 4'h0, 4'h0);
        #1;
        checks++;
        if (out !== 4'h2) begin
            errors++;
            $display("FAIL async_rst_between_edges out got %h exp %h", out, 4'h2);
        end
        // Boundary: from 1 down twice, from E up twice
        step(1, 1, 0, 4'h1, 4'h1);
        step(1, 0, 0, 4'h0, 4'h0);
`ifdef COUNT_ORDER_LOAD_SAT_EN
        step(1, 0, 0, 4'h0, 4'h0);
`else
        step(1, 0, 0, 4'h0, 4'hF);
`endif
        step(1, 1, 1, 4'hE, 4'hE);
        step(1, 0, 1, 4'h0, 4'hF);
`ifdef COUNT_ORDER_LOAD_SAT_EN
        step(1, 0, 1, 4'h0, 4'hF);
`else
        step(1, 0, 1, 4'h0, 4'h0);
`endif

        // Drain the scoreboard within a bounded number of edges
        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending got %0d exp 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_order_load.md
COUNT_ORDER_LOAD -- requirements
Module: count_order_load

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-002 The block SHALL have parameter WIDTH, default 4, giving the counter, vi and out width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state SHALL update on its rising edge only.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-low reset (0 = reset).
REQ-005 The block SHALL have port dir, input, 1 bit: count direction (1 = up, 0 = down).
REQ-006 The block SHALL have port load, input, 1 bit: synchronous parallel load (1 = load vi).
REQ-007 The block SHALL have port vi, input, WIDTH bits: the load value.
REQ-008 The block SHALL have port out, output, WIDTH bits: the counter value, driven directly from the count register with no combinational path from inputs.

Function
REQ-009 Each rising clk edge SHALL apply exactly one action, in priority order: reset, then load, then count.
REQ-010 If rst=0 at the edge, out SHALL become 0, regardless of load, dir and vi.
REQ-011 If rst=1 and load=1, out SHALL become vi on that edge; out SHALL hold vi for as long as load stays 1 with vi constant; dir SHALL be ignored.
REQ-012 If rst=1, load=0 and dir=1, out SHALL become out+1 modulo 2^WIDTH.
REQ-013 If rst=1, load=0 and dir=0, out SHALL become out-1 modulo 2^WIDTH.
REQ-014 The counter SHALL count on every edge when not in reset or load; there SHALL be no separate enable.
REQ-015 Wrap-around (default build) SHALL be: down from 0 gives 2^WIDTH-1; up from 2^WIDTH-1 gives 0.
REQ-016 A change of dir SHALL take effect on the first edge at which the new value is sampled, with no idle cycle.
REQ-017 Latency SHALL be one cycle: the action selected by the inputs sampled at edge N is visible on out after edge N.
REQ-018 On release of reset with load=0, counting SHALL start from 0 on the first edge with rst=1.

Reset
REQ-019 The reset value of out SHALL be 0.
REQ-020 Reset SHALL be sampled only at the clock edge; asserting rst=0 between edges SHALL NOT change out until the next rising edge.
REQ-021 Reset asserted mid-count or mid-load SHALL abort that operation and give out=0 on that edge.

Configuration
REQ-022 Macro COUNT_ORDER_LOAD_SAT_EN SHALL select saturation instead of wrap-around.
REQ-023 Without COUNT_ORDER_LOAD_SAT_EN, the counter SHALL wrap as in REQ-015.
REQ-024 With COUNT_ORDER_LOAD_SAT_EN defined, counting down at 0 SHALL hold 0, and counting up at 2^WIDTH-1 SHALL hold 2^WIDTH-1.
REQ-025 COUNT_ORDER_LOAD_SAT_EN SHALL NOT affect reset or load behaviour, and the interface SHALL be identical in both builds.

Verification
REQ-026 Reset dominance: rst=0, load=1, vi=7 for 2 edges -> out=0 after each edge.
REQ-027 Load: rst=1, load=1, vi=7 -> out=7 after the first edge and held at 7 for the following edges.
REQ-028 Count down with wrap: load=0, dir=0, starting from 7 -> 6,5,4,3,2,1,0,F,E on successive edges (default build).
REQ-029 Direction change and up wrap: dir set to 1 at out=C -> D,E,F,0,1 on successive edges.
REQ-030 Mid-operation events: vi=A with load pulsed for 1 edge mid-count -> out=A, then counting continues from A; rst=0 for 1 edge mid-count -> out=0.
REQ-031 Saturation (COUNT_ORDER_LOAD_SAT_EN defined): dir=0 from 1 -> 0,0; dir=1 from E -> F,F.
